// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant, binary grant index,
// owner release via done/request drop, and an optional hold-time limit.
module onehot_rr_arbiter #(
  parameter int NUM_REQ  = 8,
  parameter int IDX_W    = $clog2(NUM_REQ),
  parameter int MAX_HOLD = 0,
  parameter int HOLD_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  // state | meaning
  // IDLE  | no grant active, arbitrate from ptr whenever any req is set
  // GRANT | gnt_idx owns the resource until done, request drop or hold limit
  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;
  localparam bit                LIMIT_ON  = (MAX_HOLD != 0);

  state_t              state, state_next;
  logic [IDX_W-1:0]    ptr, ptr_next;
  logic [HOLD_W-1:0]   hold_cnt, hold_next;
  logic [NUM_REQ-1:0]  gnt_next;
  logic [IDX_W-1:0]    idx_next;
  logic                valid_next;
  logic                timeout_next;

  logic [IDX_W-1:0]    idx_wrap;
  logic [IDX_W-1:0]    search_base;
  logic [IDX_W-1:0]    sel_idx;
  logic                sel_hit;
  logic                owner_req;
  logic                vol_rel;
  logic                limit_hit;
  logic                release_now;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return IDX_W'(sum);
  endfunction

  assign idx_wrap    = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
  // On a release the search restarts just above the owner, so the owner comes last.
  assign search_base = (state == GRANT) ? idx_wrap : ptr;

  always_comb begin
    sel_hit = 1'b0;
    sel_idx = '0;
    for (int o = 0; o < NUM_REQ; o++) begin
      if (!sel_hit && req[wrap_add(search_base, o)]) begin
        sel_hit = 1'b1;
        sel_idx = wrap_add(search_base, o);
      end
    end
  end

  assign owner_req   = |(req & gnt);
  assign vol_rel     = done | ~owner_req;
  assign limit_hit   = LIMIT_ON && (hold_cnt == HOLD_LAST);
  assign release_now = vol_rel | limit_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      hold_cnt  <= hold_next;
      gnt       <= gnt_next;
      gnt_idx   <= idx_next;
      gnt_valid <= valid_next;
      timeout   <= timeout_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sel_hit) state_next = GRANT;
      GRANT:   if (release_now && !sel_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ptr_next     = ptr;
    hold_next    = hold_cnt;
    gnt_next     = gnt;
    idx_next     = gnt_idx;
    valid_next   = gnt_valid;
    timeout_next = 1'b0;
    case (state)
      IDLE: begin
        if (sel_hit) begin
          gnt_next   = NUM_REQ'(1) << sel_idx;
          idx_next   = sel_idx;
          valid_next = 1'b1;
          hold_next  = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_next     = idx_wrap;
          // A voluntary release on the limit edge is not reported as a timeout.
          timeout_next = limit_hit & ~vol_rel;
          hold_next    = '0;
          if (sel_hit) begin
            gnt_next   = NUM_REQ'(1) << sel_idx;
            idx_next   = sel_idx;
            valid_next = 1'b1;
          end else begin
            gnt_next   = '0;
            idx_next   = '0;
            valid_next = 1'b0;
          end
        end else if (hold_cnt != HOLD_SAT) begin
          hold_next = hold_cnt + 1'b1;
        end
      end
      default: begin
        gnt_next   = '0;
        idx_next   = '0;
        valid_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Bench for onehot_rr_arbiter: three instances (8 req, 8 req with hold limit 4,
// 5 req) checked every cycle against an integer-level model, plus literal checks.
module tb_onehot_rr_arbiter;

  logic clk;
  logic rst;

  logic [7:0] req8, gnt8;
  logic [2:0] idx8;
  logic       done8, valid8, to8;

  logic [7:0] reqh, gnth;
  logic [2:0] idxh;
  logic       doneh, validh, toh;

  logic [4:0] req5, gnt5;
  logic [2:0] idx5;
  logic       done5, valid5, to5;

  int n_cmp = 0;
  int n_err = 0;

  int m_valid[3] = '{default: 0};
  int m_idx[3]   = '{default: 0};
  int m_ptr[3]   = '{default: 0};
  int m_held[3]  = '{default: 0};
  int m_to[3]    = '{default: 0};

  onehot_rr_arbiter #(.NUM_REQ(8), .MAX_HOLD(0)) u_main (
    .clk(clk), .rst(rst), .req(req8), .done(done8),
    .gnt(gnt8), .gnt_idx(idx8), .gnt_valid(valid8), .timeout(to8));

  onehot_rr_arbiter #(.NUM_REQ(8), .MAX_HOLD(4)) u_hold (
    .clk(clk), .rst(rst), .req(reqh), .done(doneh),
    .gnt(gnth), .gnt_idx(idxh), .gnt_valid(validh), .timeout(toh));

  onehot_rr_arbiter #(.NUM_REQ(5), .MAX_HOLD(0)) u_odd (
    .clk(clk), .rst(rst), .req(req5), .done(done5),
    .gnt(gnt5), .gnt_idx(idx5), .gnt_valid(valid5), .timeout(to5));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // First requester at or circularly after start; -1 when nobody requests.
  function automatic int search(input int n, input int start, input logic [7:0] r);
    for (int o = 0; o < n; o++) begin
      if (r[(start + o) % n]) return (start + o) % n;
    end
    return -1;
  endfunction

  task automatic model_step(input int u, input int n, input int h,
                            input logic [7:0] r, input logic d);
    int k;
    bit vol, forced;
    m_to[u] = 0;
    if (m_valid[u] == 0) begin
      k = search(n, m_ptr[u], r);
      if (k >= 0) begin
        m_valid[u] = 1;
        m_idx[u]   = k;
        m_held[u]  = 0;
      end
    end else begin
      vol    = d || !r[m_idx[u]];
      forced = (h != 0) && (m_held[u] + 1 == h);
      if (vol || forced) begin
        m_to[u]  = (forced && !vol) ? 1 : 0;
        m_ptr[u] = (m_idx[u] + 1) % n;
        k = search(n, m_ptr[u], r);
        if (k >= 0) begin
          m_idx[u]  = k;
          m_held[u] = 0;
        end else begin
          m_valid[u] = 0;
          m_idx[u]   = 0;
        end
      end else begin
        m_held[u]++;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int u = 0; u < 3; u++) begin
        m_valid[u] = 0; m_idx[u] = 0; m_ptr[u] = 0; m_held[u] = 0; m_to[u] = 0;
      end
    end else begin
      model_step(0, 8, 0, req8, done8);
      model_step(1, 8, 4, reqh, doneh);
      model_step(2, 5, 0, {3'b000, req5}, done5);
    end
  end

  task automatic check_unit(input int u, input logic [7:0] g, input logic [2:0] i,
                            input logic v, input logic t);
    logic [7:0] exp_g;
    exp_g = (m_valid[u] != 0) ? (8'd1 << m_idx[u]) : 8'd0;
    check($sformatf("u%0d gnt", u), 32'(g), 32'(exp_g));
    check($sformatf("u%0d gnt_idx", u), 32'(i), 32'(m_idx[u]));
    check($sformatf("u%0d gnt_valid", u), 32'(v), 32'(m_valid[u]));
    check($sformatf("u%0d timeout", u), 32'(t), 32'(m_to[u]));
  endtask

  always @(negedge clk) begin
    check_unit(0, gnt8, idx8, valid8, to8);
    check_unit(1, gnth, idxh, validh, toh);
    check_unit(2, {3'b000, gnt5}, idx5, valid5, to5);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req8 = '0; reqh = '0; req5 = '0;
    done8 = 1'b0; doneh = 1'b0; done5 = 1'b0;
    tick();
    tick();
    check("reset gnt", 32'(gnt8), 32'd0);
    check("reset gnt_valid", 32'(valid8), 32'd0);
    check("reset timeout", 32'(toh), 32'd0);
    rst = 1'b0;

    // First grant from ptr=0 picks the lowest of bits 2 and 5.
    req8 = 8'b0010_0100;
    tick();
    check("first gnt", 32'(gnt8), 32'h04);
    check("first gnt_idx", 32'(idx8), 32'd2);
    check("first gnt_valid", 32'(valid8), 32'd1);
    req8 = '0;
    tick();
    check("idle after drop", 32'(valid8), 32'd0);

    // Rotation: all requesting, done every third cycle.
    do_reset();
    req8 = 8'hFF;
    tick();
    for (int t = 0; t < 9; t++) begin
      for (int c = 0; c < 3; c++) begin
        check("rotate gnt_idx", 32'(idx8), 32'(t % 8));
        check("rotate gnt_valid", 32'(valid8), 32'd1);
        done8 = (c == 2);
        tick();
        done8 = 1'b0;
      end
    end
    req8 = '0;

    // Request drop, sole requester re-grant, async reset mid-grant.
    do_reset();
    req8 = 8'b0110_0000;
    tick();
    check("drop start idx", 32'(idx8), 32'd5);
    req8 = 8'b0100_0000;
    tick();
    check("drop moves on", 32'(idx8), 32'd6);
    req8 = 8'b0010_0000;
    tick();
    check("sole owner idx", 32'(idx8), 32'd5);
    done8 = 1'b1;
    tick();
    done8 = 1'b0;
    check("sole regrant idx", 32'(idx8), 32'd5);
    check("sole regrant valid", 32'(valid8), 32'd1);
    req8 = 8'b0100_0000;
    tick();
    check("pre-reset idx", 32'(idx8), 32'd6);
    #2 rst = 1'b1;
    #1;
    check("async gnt", 32'(gnt8), 32'd0);
    check("async gnt_valid", 32'(valid8), 32'd0);
    check("async gnt_idx", 32'(idx8), 32'd0);
    check("async timeout", 32'(to8), 32'd0);
    #3 rst = 1'b0;
    req8 = 8'b1100_0000;
    tick();
    check("post-reset idx", 32'(idx8), 32'd6);
    req8 = '0;

    // Hold limit of 4 with two steady requesters.
    do_reset();
    reqh = 8'b0000_0011;
    tick();
    for (int s = 0; s < 3; s++) begin
      for (int c = 0; c < 4; c++) begin
        check("hold gnt_idx", 32'(idxh), 32'(s % 2));
        check("hold timeout", 32'(toh), 32'((s > 0 && c == 0) ? 1 : 0));
        tick();
      end
    end
    reqh = '0;

    // Five requesters: pointer wraps from 4 to 0.
    req5 = 5'b10001;
    tick();
    check("odd first idx", 32'(idx5), 32'd0);
    done5 = 1'b1;
    tick();
    done5 = 1'b0;
    check("odd owner 4", 32'(idx5), 32'd4);
    done5 = 1'b1;
    tick();
    done5 = 1'b0;
    check("odd wrap idx", 32'(idx5), 32'd0);
    req5 = '0;
    tick();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 7) == 0) req8 = 8'($urandom);
      if ($urandom_range(0, 9) == 0) reqh = 8'($urandom);
      if ($urandom_range(0, 7) == 0) req5 = 5'($urandom);
      done8 = ($urandom_range(0, 5) == 0);
      doneh = ($urandom_range(0, 11) == 0);
      done5 = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
      tick();
    end

    done8 = 1'b0; doneh = 1'b0; done5 = 1'b0;
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/onehot_rr_arbiter.md
# onehot_rr_arbiter

Round-robin arbiter that shares one resource among `NUM_REQ` requesters. It issues a registered one-hot grant together with its binary index, so downstream muxes can use either form without a separate one-hot-to-binary encoder. A grant is held until the owner releases it, drops its request, or exceeds a programmable hold limit. The block sits in front of any shared datapath that is selected by index.

## Interface

Parameters:

- `NUM_REQ`, default 8: number of requesters; legal range 2 and up, and need not be a power of 2.
- `IDX_W`, default `$clog2(NUM_REQ)`: width of the binary grant index. Derived; not overridden.
- `MAX_HOLD`, default 0: maximum number of cycles one grant may be held. The value 0 disables the limit.
- `HOLD_W`, default 16: width of the hold counter. `MAX_HOLD` must be below 2^`HOLD_W`.

Ports:

- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input `NUM_REQ`: per-requester request level. Bit i is requester i.
- `done` input 1: release pulse from the current owner. Ignored while `gnt_valid`=0.
- `gnt` output `NUM_REQ`: registered grant. Always one-hot or all zeros.
- `gnt_idx` output `IDX_W`: binary index of the set bit of `gnt`. Reads 0 when `gnt_valid`=0.
- `gnt_valid` output 1: a grant is active.
- `timeout` output 1: one-cycle pulse on the edge where a grant is force-released by `MAX_HOLD`.

## Operation

- **Reset values:** `gnt`=0, `gnt_idx`=0, `gnt_valid`=0, `timeout`=0; internal `ptr`=0, `hold_cnt`=0, state IDLE.
- **Selection function:** the first index k with `req[k]`=1, searching circularly from `ptr` upward: `ptr`, `ptr`+1, …, `NUM_REQ`-1, 0, …, `ptr`-1. No request means no selection.
- **State IDLE:**
  - If any `req` bit is set, register the selected k: `gnt`=1<<k, `gnt_idx`=k, `gnt_valid`=1, `hold_cnt`=0. Go to GRANT.
  - Otherwise stay in IDLE.
- **State GRANT, release condition** = `done`=1, OR `req[gnt_idx]`=0, OR (`MAX_HOLD`≠0 AND `hold_cnt`=`MAX_HOLD`-1).
- **State GRANT, no release:** hold all outputs and increment `hold_cnt`. The counter saturates; it does not wrap.
- **State GRANT, release:**
  - Set `ptr` = `gnt_idx`+1, wrapping from `NUM_REQ`-1 to 0.
  - Re-run the selection from the new `ptr` on the same edge.
    - Hit: grant the new owner back-to-back, `hold_cnt`=0, stay in GRANT.
    - No hit: clear `gnt`, `gnt_idx` and `gnt_valid`; go to IDLE.
  - The releasing requester is searched last, so it is re-granted only if it is the sole requester.
- **`timeout`:** asserted for exactly the cycle after a forced release. It is not asserted if `done` or a request drop coincides with the limit edge; a voluntary release takes priority.
- **Request changes while granted:** changes on non-owner bits have no effect until the next arbitration edge.
- **`ptr` updates:** only on release. `ptr` is never advanced by the IDLE-to-GRANT transition.
- **Invariant:** `gnt` = 1<<`gnt_idx` whenever `gnt_valid`=1, and `gnt`=0 otherwise.

## Timing

- **Grant latency:** `req` first sampled high in IDLE at edge N gives `gnt_valid`=1 after edge N, i.e. visible in cycle N+1.
- **Release latency:** a release sampled at edge M updates the outputs after edge M. There are zero dead cycles between successive owners when other requests are pending.
- **Hold limit:** with `MAX_HOLD`=H, an uncontested grant lasts exactly H cycles, and `timeout` is high in cycle H+1 of that owner's tenure.
- **Pointer wrap:** for non-power-of-2 `NUM_REQ`, `ptr` never takes a value ≥ `NUM_REQ`.
- **Asynchronous reset mid-grant:** all outputs go to their reset values immediately, without waiting for a clock edge. The first post-reset arbitration starts from `ptr`=0.
- **Combinational paths:** none from inputs to outputs; all outputs are flops.

## Test plan

- **Reset and first grant:** `NUM_REQ`=8; reset, then `req`=8'b0010_0100 → one cycle later `gnt`=8'b0000_0100, `gnt_idx`=2, `gnt_valid`=1.
- **Round-robin rotation:**
  - `req`=8'hFF held, with `done` pulsed every 3rd cycle.
  - Required: `gnt_idx` sequence 0,1,2,…,7,0, with each tenure lasting 3 cycles and no idle cycles between owners.
- **Request drop and sole requester:**
  - Owner 5 drops `req` with no `done` → grant moves on the next edge to the next pending index above 5.
  - With only `req[5]` asserted, pulse `done` → `gnt_idx`=5 is re-granted back-to-back.
- **Hold limit:** `MAX_HOLD`=4, `req`=8'b0000_0011 held, `done`=0 → owner 0 for 4 cycles, `timeout` pulse, owner 1 for 4 cycles, `timeout` pulse, owner 0 again.
- **Non-power-of-2 wrap:** `NUM_REQ`=5, `req`=5'b10001, owner 4 releases → `ptr` wraps to 0 and `gnt_idx`=0; `gnt_idx` never exceeds 4.
- **Async reset mid-grant:** assert `rst` between clock edges while `gnt_idx`=6 → `gnt`, `gnt_valid`, `gnt_idx` and `timeout` read 0 before the next edge. After release, `req`=8'b1100_0000 → `gnt_idx`=6, since `ptr` was reset to 0.
